sram_memory_responder: RTL and testbench

Responder for the load/store requests carried down the pipeline as MEM_R_EN / MEM_W_EN. Serves each 32-bit request as two 16-bit accesses to an external asynchronous SRAM and drops `ready` for the duration. The MEM stage uses `ready` as the pipeline freeze: while it is low, every stage register, including the ID/EX register, holds its contents.

---
 rtl/sram_memory_responder.sv | 93 +++++++++
 tb/tb_sram_memory_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sram_memory_responder.sv
// sram_memory_responder: serves 32-bit pipeline loads/stores as two 16-bit accesses to an asynchronous SRAM, freezing the pipeline via ready
module sram_memory_responder #(
  parameter int DATA_LEN      = 32,
  parameter int ADDRESS_LEN   = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int WAIT_CYCLES   = 5,
  parameter int BASE_ADDR     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDRESS_LEN-1:0]   address,
  input  logic [DATA_LEN-1:0]      write_data,
  output logic [DATA_LEN-1:0]      read_data,
  output logic                     ready,
  inout  wire  [15:0]              SRAM_DQ,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [SRAM_ADDR_LEN-2:0] word_q, word_d;
  logic [DATA_LEN-1:0]      data_q, data_d;
  logic                     wr_q, wr_d;
  logic [DATA_LEN-1:0]      read_data_q, read_data_d;
  logic                     req, last, active, drive;
  assign req    = wr_en || rd_en;
  assign last   = cnt_q == 4'(WAIT_CYCLES - 1);
  assign active = state_q == LOW || state_q == HIGH;
  assign drive  = active && wr_q;
  assign ready     = state_q == DONE || (state_q == IDLE && !req);
  assign read_data = read_data_q;
  assign SRAM_ADDR = active ? {word_q, state_q == HIGH} : '0;
  assign SRAM_WE_N = !drive;
  assign SRAM_DQ   = drive ? (state_q == HIGH ? data_q[DATA_LEN-1:DATA_LEN/2] : data_q[DATA_LEN/2-1:0]) : 16'hzzzz;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  // next-state: latch request in IDLE, hold each half for WAIT_CYCLES, capture read halves on the last edge
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    data_d      = data_q;
    wr_d        = wr_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LOW;
        cnt_d   = '0;
        word_d  = (SRAM_ADDR_LEN-1)'((address - ADDRESS_LEN'(BASE_ADDR)) >> 2);
        data_d  = write_data;
        wr_d    = wr_en;
      end
      LOW: begin
        cnt_d   = last ? '0 : cnt_q + 4'd1;
        state_d = last ? HIGH : LOW;
        if (last && !wr_q) read_data_d[DATA_LEN/2-1:0] = SRAM_DQ;
      end
      HIGH: begin
        cnt_d   = last ? '0 : cnt_q + 4'd1;
        state_d = last ? DONE : HIGH;
        if (last && !wr_q) read_data_d[DATA_LEN-1:DATA_LEN/2] = SRAM_DQ;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; asynchronous active-low reset abandons any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      read_data_q <= read_data_d;
    end
  end
endmodule

// File: tb/tb_sram_memory_responder.sv
// tb_sram_memory_responder: randomized and directed bench with a word-level memory model and scoreboard
module tb_sram_memory_responder;
  localparam int W = 5;
  logic        clk, rst, wr_en, rd_en, ready;
  logic [31:0] address, write_data, read_data;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
  logic        probe_en;
  logic [15:0] mem [0:(1<<18)-1];
  logic [31:0] mm [int];
  logic [31:0] model_last;
  logic [31:0] exp_q [$];
  int          checks, errors;

  sram_memory_responder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // SRAM model: drives stored data whenever not written; probe drives 0 to expose any DUT driver
  assign SRAM_DQ = probe_en ? 16'h0000 : (SRAM_WE_N ? mem[SRAM_ADDR] : 16'hzzzz);
  always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int wordof(input logic [31:0] a);
    return int'(((a - 32'd1024) / 4) % 32'h20000);
  endfunction

  // scoreboard monitor: a completion is ready high while a request is held
  always @(negedge clk) begin
    if (rst && ready && (wr_en || rd_en)) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("read_data", read_data, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("rst_read_data", read_data, 0);
    chk("rst_we_n", SRAM_WE_N, 1);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_ready", ready, 1);
    probe_en = 1;
    #1 chk("rst_dq_z", SRAM_DQ, 0);
    probe_en = 0;
    model_last = 0;
    @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input int n_done, input int abort_k);
    int k, guard, we_low, wd, ab;
    int done_k [$];
    logic [17:0] a0, a1, a6;
    logic rdy_after;
    logic [31:0] e;
    wd = wordof(a);
    ab = abort_k;
    if (ab >= 0) model_last = 0;
    for (int i = 0; i < n_done; i++) begin
      if (w) begin mm[wd] = d; e = model_last; end
      else begin e = mm.exists(wd) ? mm[wd] : 32'h0; model_last = e; end
      exp_q.push_back(e);
    end
    wr_en = w; rd_en = r; address = a; write_data = d;
    k = 0; guard = 0; we_low = 0; rdy_after = 1'bx; a0 = 'x; a1 = 'x; a6 = 'x;
    while (done_k.size() < n_done && guard < 80) begin
      @(negedge clk);
      guard++;
      if (k == 0) a0 = SRAM_ADDR;
      if (k == 1) a1 = SRAM_ADDR;
      if (k == W + 1) a6 = SRAM_ADDR;
      if (done_k.size() == 0 && !SRAM_WE_N) we_low++;
      if (done_k.size() == 1 && k == done_k[0] + 1) rdy_after = ready;
      if (ready) begin
        done_k.push_back(k);
        chk("addr_in_done", SRAM_ADDR, 0);
      end
      if (k == ab) begin
        #1 rst = 0;
        #1;
        chk("abort_we_n", SRAM_WE_N, 1);
        chk("abort_addr", SRAM_ADDR, 0);
        chk("abort_ready", ready, 0);
        probe_en = 1;
        #1 chk("abort_dq_z", SRAM_DQ, 0);
        probe_en = 0;
        @(posedge clk);
        #1 rst = 1;
        k = -1; we_low = 0; ab = -1;
      end
      k++;
    end
    chk("done_count", done_k.size(), n_done);
    if (done_k.size() > 0) begin
      chk("ready_low_len", done_k[0], 2 * W + 1);
      chk("we_low_len", we_low, w ? 2 * W : 0);
      chk("addr_idle", a0, 0);
      chk("addr_low", a1, {wd[16:0], 1'b0});
      chk("addr_high", a6, {wd[16:0], 1'b1});
    end
    if (n_done == 2 && done_k.size() == 2) begin
      chk("b2b_period", done_k[1] - done_k[0], 2 * W + 2);
      chk("b2b_idle_ready", rdy_after, 0);
    end
    @(posedge clk);
    #1 wr_en = 0; rd_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int wd, rw;
    logic [31:0] a;
    checks = 0; errors = 0; model_last = 0; probe_en = 0;
    rst = 0; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    do_reset();
    access(1, 0, 32'd1024, 32'hDEADBEEF, 1, -1);
    chk("sram_half0", mem[0], 16'hBEEF);
    chk("sram_half1", mem[1], 16'hDEAD);
    access(0, 1, 32'd1024, 32'h0, 1, -1);
    access(1, 0, 32'd1044, 32'h12345678, 1, -1);
    access(0, 1, 32'd1024 + 32'h80000 + 32'd20, 32'h0, 1, -1);
    access(0, 1, 32'd1026, 32'h0, 1, -1);
    access(1, 1, 32'd1028, 32'hCAFEF00D, 1, -1);
    access(0, 1, 32'd1028, 32'h0, 1, -1);
    do_reset();
    access(1, 0, 32'd1032, 32'hA5A55A5A, 1, 3);
    access(0, 1, 32'd1032, 32'h0, 1, -1);
    access(0, 1, 32'd1044, 32'h0, 2, -1);
    for (int i = 0; i < 16; i++) access(1, 0, 32'd1024 + 32'(i) * 4, $urandom, 1, -1);
    for (int i = 0; i < 30; i++) begin
      wd = $urandom_range(0, 15);
      a = 32'd1024 + 32'(wd) * 4 + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        1: a = a + 32'h80000 * 32'($urandom_range(1, 3));
        2: a = a - 32'h80000;
        default: ;
      endcase
      rw = $urandom_range(0, 2);
      access(rw != 0, rw != 1, a, $urandom, 1, -1);
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
